// File: rtl/dac_filter_pkg.sv
// Shared defaults and FSM state type for the DAC channel FIR coefficient loader.
// Optional readback is enabled with DAC_FILTER_LOADER_READBACK_EN.
package dac_filter_pkg;

  localparam int COEF_WIDTH_DEF = 25;
  localparam int LEN_DEF        = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/dac_coef_bank.sv
// LEN x COEF_WIDTH shadow register bank: one write port, one asynchronous read port,
// plus a registered readback port when DAC_FILTER_LOADER_READBACK_EN is defined.
module dac_coef_bank #(
  parameter int LEN        = 21,
  parameter int COEF_WIDTH = 25,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [COEF_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
`ifdef DAC_FILTER_LOADER_READBACK_EN
  input  logic [ADDR_W-1:0]     rb_addr,
  output logic [COEF_WIDTH-1:0] rb_data,
`endif
  output logic [COEF_WIDTH-1:0] rdata
);

  logic [COEF_WIDTH-1:0] mem [LEN];

  // Contents deliberately survive reset so a reset mid-load can be followed by a reload.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef DAC_FILTER_LOADER_READBACK_EN
  localparam logic [ADDR_W:0] LEN_EXT = (ADDR_W+1)'(LEN);

  always_ff @(posedge clk) begin
    rb_data <= ({1'b0, rb_addr} < LEN_EXT) ? mem[rb_addr] : '0;
  end
`endif

endmodule

// File: rtl/dac_filter_loader.sv
// Streams the shadow coefficient bank into the FIR config port, highest index first.
// Optional registered readback ports are added by DAC_FILTER_LOADER_READBACK_EN.
module dac_filter_loader
  import dac_filter_pkg::*;
#(
  parameter int LEN        = LEN_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int CE_GAP     = 1,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [COEF_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  err_clr,
`ifdef DAC_FILTER_LOADER_READBACK_EN
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [COEF_WIDTH-1:0] rd_data,
`endif
  output logic [COEF_WIDTH-1:0] cfg_din,
  output logic                  cfg_ce,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err
);

  // Handshake: wr_en/start/abort/err_clr are single-cycle requests sampled at posedge clk;
  // cfg_ce is a one-cycle strobe and the filter samples cfg_din only while cfg_ce=1.
  localparam int GAP_W = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;
  localparam logic [ADDR_W-1:0] IDX_TOP  = ADDR_W'(LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'((CE_GAP > 0) ? CE_GAP - 1 : 0);
  localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W+1)'(LEN);

  loader_state_t         state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [COEF_WIDTH-1:0] din_q;
  logic [COEF_WIDTH-1:0] bank_word;
  logic                  aborted_q, err_q;
  logic                  abort_hit;
  logic                  addr_ok, wr_ok, err_set;

  assign busy    = (state_q != IDLE);
  assign addr_ok = ({1'b0, wr_addr} < LEN_EXT);
  assign wr_ok   = wr_en && !busy && addr_ok;
  assign err_set = (wr_en && (busy || !addr_ok)) || (start && busy);

  dac_coef_bank #(
    .LEN        (LEN),
    .COEF_WIDTH (COEF_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .we      (wr_ok),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (idx_q),
`ifdef DAC_FILTER_LOADER_READBACK_EN
    .rb_addr (rd_addr),
    .rb_data (rd_data),
`endif
    .rdata   (bank_word)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    abort_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          idx_d   = IDX_TOP;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = IDLE;
          abort_hit = 1'b1;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else if (CE_GAP > 0) begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end else begin
          idx_d = idx_q - ADDR_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          abort_hit = 1'b1;
        end else if (gap_q == '0) begin
          state_d = LOAD;
          idx_d   = idx_q - ADDR_W'(1);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cfg_din follows the bank only during a strobe and otherwise holds the last word sent.
  assign cfg_ce  = (state_q == LOAD);
  assign cfg_din = cfg_ce ? bank_word : din_q;
  assign done    = (state_q == DONE);
  assign aborted = aborted_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= IDX_TOP;
      gap_q     <= '0;
      din_q     <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      din_q     <= cfg_din;
      aborted_q <= abort_hit;
      err_q     <= err_set | (err_q & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dac_filter_loader.sv
// Bench for dac_filter_loader: CE_GAP=1 and CE_GAP=0 instances share one stimulus stream
// and are checked every cycle against a schedule-based reference model.
module tb_dac_filter_loader;

  localparam int LEN = 21;
  localparam int W   = 25;
  localparam int AW  = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic          err_clr = 1'b0;

  logic [W-1:0] o_din  [2];
  logic         o_ce   [2];
  logic         o_busy [2];
  logic         o_done [2];
  logic         o_ab   [2];
  logic         o_err  [2];
`ifdef DAC_FILTER_LOADER_READBACK_EN
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data_g1, rd_data_g0;
`endif

  dac_filter_loader #(.LEN(LEN), .COEF_WIDTH(W), .CE_GAP(1), .ADDR_W(AW)) dut_gap1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .err_clr(err_clr),
`ifdef DAC_FILTER_LOADER_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data_g1),
`endif
    .cfg_din(o_din[0]), .cfg_ce(o_ce[0]), .busy(o_busy[0]), .done(o_done[0]),
    .aborted(o_ab[0]), .err(o_err[0])
  );

  dac_filter_loader #(.LEN(LEN), .COEF_WIDTH(W), .CE_GAP(0), .ADDR_W(AW)) dut_gap0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .err_clr(err_clr),
`ifdef DAC_FILTER_LOADER_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data_g0),
`endif
    .cfg_din(o_din[1]), .cfg_ce(o_ce[1]), .busy(o_busy[1]), .done(o_done[1]),
    .aborted(o_ab[1]), .err(o_err[1])
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit model_valid = 1'b0;

  logic [W-1:0] sh [2][LEN];
  bit           act   [2];
  int           n0    [2];
  bit           ab_p  [2];
  bit           err_m [2];
  logic [W-1:0] din_m [2];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // One clock cycle: check outputs, advance model with this cycle's inputs, clear pulses.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int p, klast, k, qsz;
      bit e_strobe, e_done, e_busy, viol;
      logic [W-1:0] e_din, w;
      p        = 1 + gap_of(d);
      klast    = 1 + (LEN - 1) * p;
      k        = cyc - n0[d];
      e_strobe = act[d] && (k <= klast) && (((k - 1) % p) == 0);
      e_done   = act[d] && (k == klast + 1);
      e_busy   = act[d];
      e_din    = e_strobe ? sh[d][LEN - 1 - (k - 1) / p] : din_m[d];

      if (model_valid) begin
        check($sformatf("cfg_ce[g%0d]",   gap_of(d)), 32'(o_ce[d]),   32'(e_strobe));
        check($sformatf("cfg_din[g%0d]",  gap_of(d)), 32'(o_din[d]),  32'(e_din));
        check($sformatf("busy[g%0d]",     gap_of(d)), 32'(o_busy[d]), 32'(e_busy));
        check($sformatf("done[g%0d]",     gap_of(d)), 32'(o_done[d]), 32'(e_done));
        check($sformatf("aborted[g%0d]",  gap_of(d)), 32'(o_ab[d]),   32'(ab_p[d]));
        check($sformatf("err[g%0d]",      gap_of(d)), 32'(o_err[d]),  32'(err_m[d]));
        qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (o_ce[d] === 1'b1) begin
          if (qsz == 0) check($sformatf("sb_extra[g%0d]", gap_of(d)), 32'(o_ce[d]), 32'd0);
          else begin
            w = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("sb_word[g%0d]", gap_of(d)), 32'(o_din[d]), 32'(w));
          end
        end
        if (o_done[d] === 1'b1)
          check($sformatf("sb_drain[g%0d]", gap_of(d)),
                (d == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
      end

      if (reset === 1'b0) begin
        act[d] = 1'b0; ab_p[d] = 1'b0; err_m[d] = 1'b0; din_m[d] = '0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (model_valid) begin
        din_m[d] = e_din;
        ab_p[d]  = 1'b0;
        viol = (wr_en && (e_busy || wr_addr >= LEN)) || (start && e_busy);
        if (wr_en && !e_busy && wr_addr < LEN) sh[d][wr_addr] = wr_data;
        if (act[d] && abort && k <= klast) begin
          act[d] = 1'b0; ab_p[d] = 1'b1;
          if (d == 0) exp_q0.delete(); else exp_q1.delete();
        end else if (e_done) begin
          act[d] = 1'b0;
        end else if (!act[d] && start && !abort) begin
          act[d] = 1'b1; n0[d] = cyc;
          for (int j = LEN - 1; j >= 0; j--)
            if (d == 0) exp_q0.push_back(sh[d][j]); else exp_q1.push_back(sh[d][j]);
        end
        err_m[d] = viol ? 1'b1 : (err_clr ? 1'b0 : err_m[d]);
      end
    end
    if (reset === 1'b0) model_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; start = 1'b0; abort = 1'b0; err_clr = 1'b0; reset = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input int a, input logic [W-1:0] v);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; n0[d] = 0; ab_p[d] = 1'b0; err_m[d] = 1'b0; din_m[d] = '0;
      for (int j = 0; j < LEN; j++) sh[d][j] = '0;
    end

    reset = 1'b0; step();
    reset = 1'b0; step();
    reset = 1'b0; step();

    // full bank, then a clean load
    for (int i = 0; i < LEN; i++) do_write(i, W'(i + 'h100));
    idle(2);
    do_start(); idle(45);

    // abort on the 4th strobe of the CE_GAP=1 instance
    do_start(); idle(6);
    abort = 1'b1; step();
    idle(5);

    // illegal writes: busy, then out of range; then clear
    do_start(); step();
    do_write(3, 'h3ff);
    idle(45);
    do_write(25, 'h1abc);
    idle(2);
    err_clr = 1'b1; step();
    idle(2);

    // start+abort together while idle
    start = 1'b1; abort = 1'b1; step();
    idle(3);

    // second start during a load
    do_start(); idle(4);
    do_start();
    idle(45);
    err_clr = 1'b1; step();

    // reset mid-load, then reload preserved data
    do_start(); idle(9);
    reset = 1'b0; step();
    step();
    do_start(); idle(45);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 99) < 15);
      wr_addr = AW'($urandom_range(0, 31));
      wr_data = W'($urandom);
      start   = ($urandom_range(0, 99) < 4);
      abort   = ($urandom_range(0, 99) < 2);
      err_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0; wr_en = 1'b0;
      end
      step();
    end
    idle(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
